// File: rtl/avalon_pio_gen.sv
// Parametrised Avalon-MM GPIO slave: per-bit direction, synchronised inputs,
// atomic set/clear, edge capture with maskable level interrupt.
module avalon_pio_gen #(
    parameter int              WIDTH       = 4,
    parameter logic [WIDTH-1:0] DATA_RESET = '0,
    parameter logic [WIDTH-1:0] DIR_RESET  = '1,
    parameter int              EDGE_TYPE   = 0,
    parameter int              SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);
    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_DIR     = 3'd1;
    localparam logic [2:0] A_IRQMASK = 3'd2;
    localparam logic [2:0] A_EDGECAP = 3'd3;
    localparam logic [2:0] A_OUTSET  = 3'd4;
    localparam logic [2:0] A_OUTCLR  = 3'd5;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] in_sync, in_d_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] edge_raw, det, clr;
    logic             wr;

    assign in_sync = sync_q[SYNC_STAGES-1];
    assign wr      = chipselect && !write_n;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_raw = in_sync & ~in_d_q;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_raw = ~in_sync & in_d_q;
        end else begin : g_any
            assign edge_raw = in_sync ^ in_d_q;
        end
    endgenerate

    // Output-direction bits never capture edges.
    assign det = edge_raw & ~dir_q;
    assign clr = (wr && address == A_EDGECAP) ? writedata : '0;

    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        if (wr) begin
            case (address)
                A_DATA:    data_d = writedata;
                A_DIR:     dir_d  = writedata;
                A_IRQMASK: mask_d = writedata;
                A_OUTSET:  data_d = data_q | writedata;
                A_OUTCLR:  data_d = data_q & ~writedata;
                default:   ;
            endcase
        end
        // A fresh detection wins over a simultaneous write-1-clear.
        ecap_d = (ecap_q & ~clr) | det;
    end

    always_comb begin
        rdata_d = '0;
        if (chipselect) begin
            case (address)
                A_DATA:    rdata_d = (dir_q & data_q) | (~dir_q & in_sync);
                A_DIR:     rdata_d = dir_q;
                A_IRQMASK: rdata_d = mask_q;
                A_EDGECAP: rdata_d = ecap_q;
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            in_d_q  <= '0;
            data_q  <= DATA_RESET;
            dir_q   <= DIR_RESET;
            mask_q  <= '0;
            ecap_q  <= '0;
            rdata_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
            in_d_q  <= in_sync;
            data_q  <= data_d;
            dir_q   <= dir_d;
            mask_q  <= mask_d;
            ecap_q  <= ecap_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign out_port = data_q;
    assign out_en   = dir_q;
    assign irq      = |(ecap_q & mask_q);
endmodule

// File: tb/tb_avalon_pio_gen.sv
// Bench for avalon_pio_gen: a rising-edge and a falling-edge instance share one bus,
// checked every cycle against a register-level model plus directed literal checks.
module tb_avalon_pio_gen;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] addr = 3'd0;
    logic       cs = 1'b0;
    logic       wn = 1'b1;
    logic [3:0] wd = 4'h0;
    logic [3:0] in_port = 4'h0;
    logic [3:0] rdata_r, rdata_f, op_r, op_f, oe_r, oe_f;
    logic       irq_r, irq_f;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    avalon_pio_gen #(.WIDTH(4), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wn),
        .writedata(wd), .readdata(rdata_r), .in_port(in_port), .out_port(op_r),
        .out_en(oe_r), .irq(irq_r));

    avalon_pio_gen #(.WIDTH(4), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wn),
        .writedata(wd), .readdata(rdata_f), .in_port(in_port), .out_port(op_f),
        .out_en(oe_f), .irq(irq_f));

    // Register-level model; h[k] is in_port as sampled k+1 clocks ago.
    logic [3:0] m_data, m_dir, m_mask;
    logic [3:0] m_ecap [0:1];
    logic [3:0] m_rd   [0:1];
    logic [3:0] h      [0:3];

    wire [3:0] m_insync = h[SS-1];
    wire [3:0] m_ind    = h[SS];
    wire       m_wr     = cs && !wn;
    wire [3:0] m_clr    = (m_wr && addr == 3'd3) ? wd : 4'h0;

    function automatic logic [3:0] m_det(input int et);
        logic [3:0] e;
        e = (et == 0) ? (m_insync & ~m_ind) : (~m_insync & m_ind);
        return e & ~m_dir;
    endfunction

    function automatic logic [3:0] m_read(input int et);
        if (!cs) return 4'h0;
        case (addr)
            3'd0:    return (m_dir & m_data) | (~m_dir & m_insync);
            3'd1:    return m_dir;
            3'd2:    return m_mask;
            3'd3:    return m_ecap[et];
            default: return 4'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data <= 4'h0;
            m_dir  <= 4'hF;
            m_mask <= 4'h0;
            for (int i = 0; i < 2; i++) begin
                m_ecap[i] <= 4'h0;
                m_rd[i]   <= 4'h0;
            end
            for (int k = 0; k < 4; k++) h[k] <= 4'h0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_ecap[i] <= (m_ecap[i] & ~m_clr) | m_det(i);
                m_rd[i]   <= m_read(i);
            end
            if (m_wr) begin
                case (addr)
                    3'd0: m_data <= wd;
                    3'd1: m_dir  <= wd;
                    3'd2: m_mask <= wd;
                    3'd4: m_data <= m_data | wd;
                    3'd5: m_data <= m_data & ~wd;
                    default: ;
                endcase
            end
            h[0] <= in_port;
            for (int k = 1; k < 4; k++) h[k] <= h[k-1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("out_port_r", op_r, m_data);
        chk("out_en_r",   oe_r, m_dir);
        chk("readdata_r", rdata_r, m_rd[0]);
        chk("irq_r",      irq_r, |(m_ecap[0] & m_mask));
        chk("out_port_f", op_f, m_data);
        chk("out_en_f",   oe_f, m_dir);
        chk("readdata_f", rdata_f, m_rd[1]);
        chk("irq_f",      irq_f, |(m_ecap[1] & m_mask));
    end

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        @(negedge clk);
        cs = 1'b1; wn = 1'b0; addr = a; wd = d;
        @(negedge clk);
        cs = 1'b0; wn = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [3:0] vr, output logic [3:0] vf);
        @(negedge clk);
        cs = 1'b1; wn = 1'b1; addr = a;
        @(negedge clk);
        vr = rdata_r; vf = rdata_f;
        cs = 1'b0;
    endtask

    initial begin
        logic [3:0] vr, vf;
        repeat (3) @(negedge clk);
        chk("rst_out_port", op_r, 4'h0);
        chk("rst_out_en", oe_r, 4'hF);
        chk("rst_irq", irq_r, 1'b0);
        chk("rst_readdata", rdata_r, 4'h0);
        reset_n = 1'b1;
        rd(3'd1, vr, vf);           chk("dir_after_reset", vr, 4'hF);

        // Write/readback and atomic set/clear
        wr(3'd0, 4'hA);
        rd(3'd0, vr, vf);           chk("data_readback", vr, 4'hA);
        wr(3'd4, 4'h1);             chk("outset", op_r, 4'hB);
        wr(3'd5, 4'h8);             chk("outclr", op_r, 4'h3);
        rd(3'd4, vr, vf);           chk("outset_reads_0", vr, 4'h0);

        // Input sampling through the synchroniser
        wr(3'd1, 4'h0);
        @(negedge clk); in_port = 4'h5;
        rd(3'd0, vr, vf);           chk("input_too_early", vr, 4'h0);
        repeat (3) @(negedge clk);
        rd(3'd0, vr, vf);           chk("input_read", vr, 4'h5);
        wr(3'd1, 4'hC);
        wr(3'd0, 4'hF);
        rd(3'd0, vr, vf);           chk("mixed_dir_read", vr, 4'hD);

        // Rising edge capture and interrupt
        wr(3'd1, 4'h0);
        @(negedge clk); in_port = 4'h0;
        repeat (4) @(negedge clk);
        wr(3'd3, 4'hF);
        wr(3'd2, 4'h2);
        chk("irq_idle", irq_r, 1'b0);
        in_port = 4'h2;
        repeat (2) @(negedge clk);  chk("irq_before_E0p2", irq_r, 1'b0);
        @(negedge clk);             chk("irq_at_E0p2", irq_r, 1'b1);
        rd(3'd3, vr, vf);           chk("edgecap_bit1", vr, 4'h2);
        in_port = 4'h3;
        repeat (3) @(negedge clk);
        rd(3'd3, vr, vf);           chk("edgecap_bit0", vr, 4'h3);
        chk("irq_still_high", irq_r, 1'b1);
        wr(3'd3, 4'h2);             chk("irq_cleared", irq_r, 1'b0);
        rd(3'd3, vr, vf);           chk("edgecap_after_clr", vr, 4'h1);

        // Clear and new detection on the same clock: set wins
        in_port = 4'h2;
        repeat (3) @(negedge clk);
        in_port = 4'h3;
        @(negedge clk);
        wr(3'd3, 4'h1);
        rd(3'd3, vr, vf);           chk("set_beats_clear", vr, 4'h1);

        // Falling mode with an output bit
        wr(3'd1, 4'h8);
        wr(3'd3, 4'hF);
        in_port = 4'hF;
        repeat (4) @(negedge clk);
        rd(3'd3, vr, vf);           chk("rise_ecap_gated", vr, 4'h4);
        chk("fall_ignores_rise", vf, 4'h0);
        in_port = 4'h0;
        repeat (4) @(negedge clk);
        rd(3'd3, vr, vf);           chk("fall_ecap", vf, 4'h7);
        chk("rise_ignores_fall", vr, 4'h4);
        chk("irq_fall", irq_f, 1'b1);
        chk("irq_rise_masked", irq_r, 1'b0);
        wr(3'd1, 4'hF);
        rd(3'd3, vr, vf);           chk("dir_keeps_pending", vf, 4'h7);

        // Reset asserted in the middle of a read
        wr(3'd0, 4'h5);
        in_port = 4'hF;
        @(negedge clk);
        cs = 1'b1; wn = 1'b1; addr = 3'd1;
        @(posedge clk); #2;
        chk("pre_reset_readdata", rdata_r, 4'hF);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_port", op_r, 4'h0);
        chk("mid_rst_out_en", oe_f, 4'hF);
        chk("mid_rst_irq_f", irq_f, 1'b0);
        chk("mid_rst_readdata", rdata_r, 4'h0);
        cs = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(3'd1, vr, vf);           chk("dir_after_midrst", vr, 4'hF);
        repeat (4) @(negedge clk);
        rd(3'd3, vr, vf);           chk("ecap_after_midrst", vr, 4'h0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
